esm_instr_feeder: RTL and testbench

- Producer side of the ESM instruction interface.
- Accepts a program of RV32I instruction words from an upstream source over a valid/ready handshake and buffers them in an internal FIFO.
- Issues one word per clock onto the ESM Instr_in/RegWrite/ALUSrc inputs, deriving RegWrite and ALUSrc from the opcode.
- Terminates the stream with a programmable run of all-zero end-of-stream words.

---
 rtl/esm_pkg.sv | 16 +
 rtl/esm_ctrl_decode.sv | 19 +
 rtl/esm_instr_feeder.sv | 125 ++++++++++++
 tb/tb_esm_instr_feeder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// esm_pkg: shared opcodes, feeder state encoding and the end-of-stream word for the ESM interface.
package esm_pkg;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_WORD = '0;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} feeder_state_e;
endpackage

// File: rtl/esm_ctrl_decode.sv
// esm_ctrl_decode: maps an RV32I opcode to the ESM RegWrite/ALUSrc control pair.
module esm_ctrl_decode
    import esm_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       reg_write,
    output logic       alu_src
);
    always_comb begin
        {reg_write, alu_src} = 2'b00;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JALR: {reg_write, alu_src} = 2'b11;
            OPC_OP, OPC_JAL:                                    {reg_write, alu_src} = 2'b10;
            OPC_STORE:                                          {reg_write, alu_src} = 2'b01;
            OPC_BRANCH:                                         {reg_write, alu_src} = 2'b00;
            default:                                            {reg_write, alu_src} = 2'b00;
        endcase
    end
endmodule

// File: rtl/esm_instr_feeder.sv
// esm_instr_feeder: buffers an upstream instruction program in a FIFO and issues it
// one word per clock to the ESM, followed by a run of all-zero end-of-stream words.
module esm_instr_feeder
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = 32,
    parameter int DEPTH                 = 8,
    parameter int DRAIN_NOPS            = 20,
    parameter int CNT_W                 = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [Instruction_word_size-1:0] in_instr,
    input  logic                             in_last,
    output logic [Instruction_word_size-1:0] Instr_in,
    output logic                             RegWrite,
    output logic                             ALUSrc,
    output logic                             busy,
    output logic                             done,
    output logic [CNT_W-1:0]                 issued_count
);
    localparam int W  = Instruction_word_size;
    localparam int AW = $clog2(DEPTH);
    localparam int DW = DRAIN_NOPS > 0 ? $clog2(DRAIN_NOPS + 1) : 1;

    feeder_state_e  state_q, state_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W:0]     mem_q [DEPTH];
    logic           last_seen_q, last_seen_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic [W-1:0]   instr_q, instr_d;
    logic           reg_write_q, reg_write_d, alu_src_q, alu_src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           full, empty, push, pop, head_last, dec_rw, dec_as;
    logic [W-1:0]   head_instr;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = wr_ptr_q == rd_ptr_q;
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign {head_last, head_instr} = mem_q[rd_ptr_q[AW-1:0]];
    assign in_ready = !full && !last_seen_q && state_q != DONE;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = state_q == STREAM && !empty && !flush;

    esm_ctrl_decode u_dec (
        .opcode   (head_instr[6:0]),
        .reg_write(dec_rw),
        .alu_src  (dec_as)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
        last_seen_d = last_seen_q | (push & in_last);
        drain_d     = drain_q;
        instr_d     = pop ? head_instr : W'(NOP_WORD);
        reg_write_d = pop & dec_rw;
        alu_src_d   = pop & dec_as;
        cnt_d       = cnt_q + CNT_W'(pop);
        case (state_q)
            IDLE:    if (start) begin
                         state_d = STREAM;
                         cnt_d   = '0;
                     end
            STREAM:  if (pop && head_last) begin
                         state_d = DRAIN;
                         drain_d = DW'(DRAIN_NOPS);
                     end
            DRAIN:   if (drain_q == '0) state_d = DONE;
                     else drain_d = drain_q - 1'b1;
            DONE:    if (start) begin
                         state_d     = IDLE;
                         last_seen_d = 1'b0;
                     end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            last_seen_d = 1'b0;
            cnt_d       = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_seen_q <= 1'b0;
            drain_q     <= '0;
            instr_q     <= '0;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_seen_q <= last_seen_d;
            drain_q     <= drain_d;
            instr_q     <= instr_d;
            reg_write_q <= reg_write_d;
            alu_src_q   <= alu_src_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_instr};
    end

    assign Instr_in     = instr_q;
    assign RegWrite     = reg_write_q;
    assign ALUSrc       = alu_src_q;
    assign busy         = state_q == STREAM || state_q == DRAIN;
    assign done         = state_q == DONE;
    assign issued_count = cnt_q;
endmodule

// File: tb/tb_esm_instr_feeder.sv
// tb_esm_instr_feeder: directed checks of issue order, decode, backpressure, flush, reset and restart.
module tb_esm_instr_feeder;
    logic        clk, rst, start, flush, in_valid, in_ready, in_last;
    logic [31:0] in_instr, Instr_in;
    logic        RegWrite, ALUSrc, busy, done;
    logic [15:0] issued_count;
    int          errors = 0, checks = 0;

    esm_instr_feeder dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_last(in_last),
        .Instr_in(Instr_in), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .busy(busy), .done(done), .issued_count(issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic l);
        in_valid = 1'b1;
        in_instr = w;
        in_last  = l;
        check("push_rdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cnt);
        int c = 0;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("done", done, 1);
        check("issued", issued_count, exp_cnt);
    endtask

    function automatic logic [31:0] fw(input int i);
        return {12'(i + 1), 5'd4, 3'd0, 5'd5, 7'h13};
    endfunction

    function automatic logic [31:0] ww(input int i);
        return {7'd0, 5'(i + 1), 5'd1, 3'd0, 5'd2, 7'h33};
    endfunction

    logic [31:0] w3 [3] = '{32'h00A00093, 32'h01400113, 32'h002081B3};
    logic [1:0]  d3 [3] = '{2'b11, 2'b11, 2'b10};
    logic [31:0] w4 [4] = '{32'h0042A423, 32'h00A2E063, 32'h004000EF, 32'h00008067};
    logic [1:0]  d4 [4] = '{2'b01, 2'b00, 2'b10, 2'b11};

    initial begin
        int nz, acc, k;
        logic r;
        rst = 1'b1; start = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_instr = '0;
        #3;
        check("rst_instr", Instr_in, 0);
        check("rst_flags", {RegWrite, ALUSrc, busy, done}, 0);
        check("rst_cnt", issued_count, 0);
        @(negedge clk) rst = 1'b0;

        // basic issue
        for (int i = 0; i < 3; i++) push(w3[i], i == 2);
        pulse_start();
        @(negedge clk) check("b_pre", Instr_in, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b_instr", Instr_in, w3[i]);
            check("b_ctl", {RegWrite, ALUSrc}, d3[i]);
        end
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Instr_in != 0 || done || !busy) nz++;
        end
        check("b_drain", nz, 0);
        @(negedge clk);
        check("b_done", {done, busy}, 2'b10);
        check("b_cnt", issued_count, 3);

        // restart and decode
        in_valid = 1'b1; in_instr = 32'hDEADBEEF;
        check("done_rdy", in_ready, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        check("rs_state", {done, busy, in_ready}, 3'b001);
        for (int i = 0; i < 4; i++) push(w4[i], i == 3);
        pulse_start();
        @(negedge clk) check("d_pre", Instr_in, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("d_instr", Instr_in, w4[i]);
            check("d_ctl", {RegWrite, ALUSrc}, d4[i]);
        end
        wait_done(4);

        // backpressure and bubbles
        pulse_start();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_instr = fw(acc); in_last = 1'b0;
            r = in_ready;
            @(posedge clk); #1;
            if (r) acc++;
        end
        in_valid = 1'b0;
        check("bp_acc", acc, 8);
        check("bp_rdy", in_ready, 0);
        pulse_start();
        @(negedge clk) check("bp_pre", Instr_in, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bp_instr", Instr_in, fw(i));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bub_instr", {Instr_in, RegWrite, ALUSrc}, 0);
            check("bub_cnt", issued_count, 8);
        end
        push(32'h00C00513, 1'b1);
        @(negedge clk) check("bub_4", Instr_in, 0);
        @(negedge clk) check("bp_last", Instr_in, 32'h00C00513);
        wait_done(9);

        // wrap-around
        pulse_start();
        pulse_start();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    in_valid = 1'b1; in_instr = ww(i); in_last = (i == 19);
                    check("wrap_rdy", in_ready, 1);
                    @(posedge clk); #1;
                end
                in_valid = 1'b0; in_last = 1'b0;
            end
            begin
                k = 0;
                for (int c = 0; c < 200 && k < 20; c++) begin
                    @(negedge clk);
                    if (Instr_in != 0) begin
                        check("wrap_instr", Instr_in, ww(k));
                        check("wrap_ctl", {RegWrite, ALUSrc}, 2'b10);
                        k++;
                    end
                end
                check("wrap_n", k, 20);
            end
        join
        wait_done(20);

        // flush mid-stream
        pulse_start();
        for (int i = 0; i < 5; i++) push(fw(i + 10), 1'b0);
        pulse_start();
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("fl_instr", Instr_in, 0);
        check("fl_state", {busy, done, in_ready}, 3'b001);
        check("fl_cnt", issued_count, 0);
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("fl_empty", Instr_in, 0);
        end
        push(32'h00A00093, 1'b1);
        @(negedge clk) check("fl_bub", Instr_in, 0);
        @(negedge clk) check("fl_word", Instr_in, 32'h00A00093);
        check("fl_cnt1", issued_count, 1);

        // async reset during drain
        @(negedge clk) check("ar_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_instr", Instr_in, 0);
        check("ar_flags", {RegWrite, ALUSrc, busy, done}, 0);
        check("ar_cnt", issued_count, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) check("ar_rdy", {in_ready, done}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
